// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: serializer state encoding
// and the idle line level.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam logic TXD_IDLE = 1'b1;

endpackage

// File: rtl/uart_tx_ser.sv
// UART frame serializer with baud counter and valid/ready load port.
// Even parity bit is inserted when UART_TX_PARITY_EN is defined.
module uart_tx_ser
  import uart_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int CLK_PER_BIT = 868
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              txd,
  output logic              tx_busy
);

  localparam int CW = $clog2(CLK_PER_BIT);
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

  tx_state_t         state, state_nxt;
  logic [CW-1:0]     cnt;
  logic [BW-1:0]     bidx;
  logic [DATA_W-1:0] shreg;
  logic              baud_done;
  logic              load;

  assign baud_done = (cnt == CNT_LAST);
  // Accepting on the last STOP cycle chains frames without an idle gap.
  assign ld_ready  = (state == IDLE) || ((state == STOP) && baud_done);
  assign load      = ld_valid && ld_ready;
  assign tx_busy   = (state != IDLE);

`ifdef UART_TX_PARITY_EN
  logic par;

  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

  always_ff @(posedge clk) begin
    if (load) par <= even_parity(ld_data);
  end
`endif

  always_comb begin
    state_nxt = state;
    txd       = TXD_IDLE;
    case (state)
      IDLE: begin
        if (load) state_nxt = START;
      end
      START: begin
        txd = 1'b0;
        if (baud_done) state_nxt = DATA;
      end
      DATA: begin
        txd = shreg[0];
        if (baud_done && (bidx == BIT_LAST)) begin
`ifdef UART_TX_PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = STOP;
`endif
        end
      end
      PARITY: begin
`ifdef UART_TX_PARITY_EN
        txd = par;
`endif
        if (baud_done) state_nxt = STOP;
      end
      STOP: begin
        txd = TXD_IDLE;
        if (baud_done) state_nxt = load ? START : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      cnt   <= '0;
      bidx  <= '0;
    end else begin
      state <= state_nxt;
      if ((state == IDLE) || baud_done) cnt <= '0;
      else                              cnt <= cnt + CW'(1);
      if (state != DATA)  bidx <= '0;
      else if (baud_done) bidx <= bidx + BW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (load)                            shreg <= ld_data;
    else if ((state == DATA) && baud_done) shreg <= shreg >> 1;
  end

endmodule

// File: rtl/uart_tx_bufq.sv
// Buffered UART transmitter: FIFO with flush and sticky overflow feeding
// uart_tx_ser. Optional parity via macro UART_TX_PARITY_EN.
module uart_tx_bufq
  import uart_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 16,
  parameter int CLK_PER_BIT = 868
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     wr_valid,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     wr_ready,
  input  logic                     flush,
  input  logic                     ovf_clr,
  output logic                     txd,
  output logic                     tx_busy,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr, rptr;
  logic              full, push, pop;
  logic              ld_valid, ld_ready;
  logic              ovf_set;

  assign full     = (level == FULL_LVL);
  assign wr_ready = rstn && !full && !flush;
  assign push     = wr_valid && wr_ready;
  // Flush masks the load request so it wins over a same-cycle pop.
  assign ld_valid = (level != '0) && !flush;
  assign pop      = ld_valid && ld_ready;
  assign ovf_set  = wr_valid && full;

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
      ovf   <= 1'b0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (flush) begin
        rptr  <= wptr;
        level <= '0;
      end else begin
        if (pop) rptr <= rptr + AW'(1);
        case ({push, pop})
          2'b10:   level <= level + LW'(1);
          2'b01:   level <= level - LW'(1);
          default: level <= level;
        endcase
      end
      if (ovf_set)      ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

  uart_tx_ser #(
    .DATA_W      (DATA_W),
    .CLK_PER_BIT (CLK_PER_BIT)
  ) u_ser (
    .clk      (clk),
    .rstn     (rstn),
    .ld_valid (ld_valid),
    .ld_data  (mem[rptr]),
    .ld_ready (ld_ready),
    .txd      (txd),
    .tx_busy  (tx_busy)
  );

endmodule

// File: tb/tb_uart_tx_bufq.sv
// Directed bench for uart_tx_bufq: DEPTH=4 and DEPTH=16 instances, CLK_PER_BIT=4,
// with a line decoder per instance. Parity checks run when UART_TX_PARITY_EN is set.
module tb_uart_tx_bufq;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FL = NB * CPB;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       a_wr_valid, a_flush, a_ovf_clr, a_wr_ready, txd_a, a_busy, a_ovf;
  logic [7:0] a_wr_data;
  logic [2:0] a_level;
  logic       b_wr_valid, b_flush, b_ovf_clr, b_wr_ready, txd_b, b_busy, b_ovf;
  logic [7:0] b_wr_data;
  logic [4:0] b_level;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int fr_cnt[2] = '{0, 0};
  int fr_bad[2] = '{0, 0};
  logic [7:0] fr_data[2][64];
  logic       fr_par[2][64];
  int         fr_start[2][64];

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  uart_tx_bufq #(.DATA_W(8), .DEPTH(4), .CLK_PER_BIT(CPB)) u_dut_a (
    .clk(clk), .rstn(rstn), .wr_valid(a_wr_valid), .wr_data(a_wr_data),
    .wr_ready(a_wr_ready), .flush(a_flush), .ovf_clr(a_ovf_clr), .txd(txd_a),
    .tx_busy(a_busy), .level(a_level), .ovf(a_ovf)
  );

  uart_tx_bufq #(.DATA_W(8), .DEPTH(16), .CLK_PER_BIT(CPB)) u_dut_b (
    .clk(clk), .rstn(rstn), .wr_valid(b_wr_valid), .wr_data(b_wr_data),
    .wr_ready(b_wr_ready), .flush(b_flush), .ovf_clr(b_ovf_clr), .txd(txd_b),
    .tx_busy(b_busy), .level(b_level), .ovf(b_ovf)
  );

  function automatic logic txd_of(input int id);
    return (id == 0) ? txd_a : txd_b;
  endfunction

  // Line decoder: samples mid-bit, records each complete frame and its start cycle.
  task automatic mon(input int id);
    int t, k, st;
    logic [7:0] d;
    logic p, ab;
    forever begin
      @(negedge clk);
      if (rstn && (txd_of(id) == 1'b0)) begin
        st = cyc; t = 0; d = '0; p = 1'b0; ab = 1'b0;
        while (t < FL - 1) begin
          @(negedge clk);
          t++;
          if (!rstn) begin
            ab = 1'b1;
            break;
          end
          if ((t % CPB) == (CPB / 2)) begin
            k = t / CPB;
            if (k >= 1 && k <= 8) d[k-1] = txd_of(id);
            else if (k == NB - 1) begin
              if (txd_of(id) !== 1'b1) fr_bad[id]++;
            end else if (k == 9) p = txd_of(id);
          end
        end
`ifdef UART_TX_PARITY_EN
        if (!ab && (p !== ^d)) fr_bad[id]++;
`endif
        if (!ab && fr_cnt[id] < 64) begin
          fr_data[id][fr_cnt[id]]  = d;
          fr_par[id][fr_cnt[id]]   = p;
          fr_start[id][fr_cnt[id]] = st;
          fr_cnt[id]++;
        end
      end
    end
  endtask

  initial mon(0);
  initial mon(1);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_frames(input int id, input int n, input int budget);
    int w;
    w = 0;
    while (fr_cnt[id] < n && w < budget) begin
      @(negedge clk);
      w++;
    end
    chk("frame_count", fr_cnt[id], n);
  endtask

  task automatic wait_idle_a();
    int w;
    w = 0;
    while ((a_busy || a_level != 0) && w < 400) begin
      @(negedge clk);
      w++;
    end
    chk("idle_wait", {a_busy, a_level}, 0);
  endtask

  // Line level expected j cycles after the start edge of an 0xA5 frame.
  function automatic logic exp_a5(input int j);
    int k;
    logic [7:0] v;
    v = 8'hA5;
    k = j / CPB;
    if (k == 0)      return 1'b0;
    if (k <= 8)      return v[k-1];
    if (k == NB - 1) return 1'b1;
    return 1'b0;
  endfunction

  int p, n0, pk, tmo, w;

  initial begin
    a_wr_valid = 0; a_wr_data = 0; a_flush = 0; a_ovf_clr = 0;
    b_wr_valid = 0; b_wr_data = 0; b_flush = 0; b_ovf_clr = 0;
    repeat (3) @(negedge clk);
    chk("rst_txd", txd_a, 1'b1);
    chk("rst_busy", a_busy, 1'b0);
    chk("rst_level", a_level, 0);
    chk("rst_ovf", {a_ovf, b_ovf}, 0);
    chk("rst_wr_ready", {a_wr_ready, b_wr_ready}, 0);
    rstn = 1'b1;
    @(negedge clk);
    chk("rel_wr_ready", {a_wr_ready, b_wr_ready}, 2'b11);

    // single 0xA5, cycle-exact line check
    p = cyc;
    a_wr_data = 8'hA5; a_wr_valid = 1'b1;
    @(negedge clk);
    a_wr_valid = 1'b0;
    chk("single_level", a_level, 1);
    @(negedge clk);
    for (int j = 0; j < FL; j++) begin
      chk("single_txd", txd_a, exp_a5(j));
      if (j == 0) chk("single_busy", a_busy, 1'b1);
      @(negedge clk);
    end
    chk("single_end_txd", txd_a, 1'b1);
    chk("single_end_busy", a_busy, 1'b0);
    wait_frames(0, 1, 10);
    chk("single_data", fr_data[0][0], 8'hA5);
    chk("single_start", fr_start[0][0], p + 2);

    // burst 1..4 on DEPTH=4
    n0 = fr_cnt[0]; p = cyc; pk = 0;
    for (int i = 0; i < 4; i++) begin
      a_wr_data = 8'(i + 1); a_wr_valid = 1'b1;
      @(negedge clk);
      if (int'(a_level) > pk) pk = int'(a_level);
    end
    a_wr_valid = 1'b0;
    repeat (FL) begin
      @(negedge clk);
      if (int'(a_level) > pk) pk = int'(a_level);
    end
    chk("burst_peak", pk, 3);
    wait_frames(0, n0 + 4, 5 * FL);
    for (int i = 0; i < 4; i++) chk("burst_data", fr_data[0][n0+i], i + 1);
    chk("burst_start", fr_start[0][n0], p + 2);
    for (int i = 1; i < 4; i++) chk("burst_gap", fr_start[0][n0+i] - fr_start[0][n0+i-1], FL);
    wait_idle_a();

    // overflow with serializer busy
    n0 = fr_cnt[0];
    a_wr_data = 8'h10; a_wr_valid = 1'b1;
    @(negedge clk);
    a_wr_valid = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 1; i <= 6; i++) begin
      a_wr_data = 8'(8'h10 + i); a_wr_valid = 1'b1;
      if (i == 6) a_ovf_clr = 1'b1;
      #1;
      if (i == 5) begin
        chk("ovf_wr_ready", a_wr_ready, 1'b0);
        chk("ovf_level", a_level, 4);
        chk("ovf_pre", a_ovf, 1'b0);
      end
      @(negedge clk);
      if (i == 5) chk("ovf_set", a_ovf, 1'b1);
    end
    a_wr_valid = 1'b0; a_ovf_clr = 1'b0;
    chk("ovf_set_wins", a_ovf, 1'b1);
    repeat (3) @(negedge clk);
    chk("ovf_hold", a_ovf, 1'b1);
    a_ovf_clr = 1'b1;
    @(negedge clk);
    a_ovf_clr = 1'b0;
    chk("ovf_clr", a_ovf, 1'b0);
    wait_frames(0, n0 + 5, 7 * FL);
    for (int i = 0; i < 5; i++) chk("ovf_data", fr_data[0][n0+i], 8'h10 + i);
    repeat (2 * FL) @(negedge clk);
    chk("ovf_no_dropped", fr_cnt[0], n0 + 5);
    wait_idle_a();

    // flush during DATA of the first word
    n0 = fr_cnt[0]; p = cyc;
    for (int i = 0; i < 3; i++) begin
      a_wr_data = 8'(8'h21 + i); a_wr_valid = 1'b1;
      @(negedge clk);
    end
    a_wr_valid = 1'b0;
    while (cyc < p + 10) @(negedge clk);
    chk("flush_pre_level", a_level, 2);
    a_flush = 1'b1;
    #1;
    chk("flush_wr_ready", a_wr_ready, 1'b0);
    @(negedge clk);
    a_flush = 1'b0;
    chk("flush_level", a_level, 0);
    chk("flush_busy", a_busy, 1'b1);
    wait_frames(0, n0 + 1, 2 * FL);
    chk("flush_data", fr_data[0][n0], 8'h21);
    repeat (2 * FL) @(negedge clk);
    chk("flush_no_more", fr_cnt[0], n0 + 1);
    chk("flush_idle", a_busy, 1'b0);

`ifdef UART_TX_PARITY_EN
    n0 = fr_cnt[0];
    a_wr_data = 8'h07; a_wr_valid = 1'b1;
    @(negedge clk);
    a_wr_data = 8'h03;
    @(negedge clk);
    a_wr_valid = 1'b0;
    wait_frames(0, n0 + 2, 4 * FL);
    chk("par_07_data", fr_data[0][n0], 8'h07);
    chk("par_07_bit", fr_par[0][n0], 1'b1);
    chk("par_03_data", fr_data[0][n0+1], 8'h03);
    chk("par_03_bit", fr_par[0][n0+1], 1'b0);
    chk("par_frame_len", fr_start[0][n0+1] - fr_start[0][n0], 44);
`endif

    // 20 words through DEPTH=16 across the pointer wrap
    tmo = 0;
    for (int i = 0; i < 20; i++) begin
      b_wr_data = 8'(8'h40 + i); b_wr_valid = 1'b1;
      w = 0;
      while (!b_wr_ready && w < 200) begin
        @(negedge clk);
        w++;
      end
      if (w == 200) tmo++;
      @(negedge clk);
    end
    b_wr_valid = 1'b0;
    chk("wrap_push_timeout", tmo, 0);
    wait_frames(1, 20, 25 * FL);
    for (int i = 0; i < 20; i++) chk("wrap_data", fr_data[1][i], 8'h40 + i);

    // asynchronous reset mid-frame
    b_wr_data = 8'h60; b_wr_valid = 1'b1;
    @(negedge clk);
    b_wr_data = 8'h61;
    @(negedge clk);
    b_wr_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst_mid_pre_busy", b_busy, 1'b1);
    chk("rst_mid_pre_level", b_level, 1);
    rstn = 1'b0;
    #1;
    chk("rst_mid_txd", txd_b, 1'b1);
    chk("rst_mid_level", b_level, 0);
    chk("rst_mid_busy", b_busy, 1'b0);
    chk("rst_mid_wr_ready", b_wr_ready, 1'b0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("rst_mid_rel_ready", b_wr_ready, 1'b1);
    repeat (2 * FL) @(negedge clk);
    chk("rst_mid_no_frame", fr_cnt[1], 20);
    chk("rst_mid_idle", {b_busy, txd_b}, 2'b01);

    chk("framing_a", fr_bad[0], 0);
    chk("framing_b", fr_bad[1], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
